// File: rtl/load_extend_pkg.sv
// Shared definitions for the load extend unit: access-size encodings and
// small helpers for access width and alignment.
package load_extend_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(size_e size);
    return 32'd1 << size;
  endfunction

  // True when the offset is a multiple of the access size and the size
  // exists on a datapath of data_w bits (a dword needs 64 bits).
  function automatic logic is_aligned(size_e size, logic [2:0] offset,
                                      int unsigned data_w);
    logic [2:0] low_mask;
    low_mask = 3'(size_bytes(size) - 32'd1);
    if (size == SIZE_DWORD && data_w < 32'd64) return 1'b0;
    return (offset & low_mask) == 3'b000;
  endfunction

endpackage

// File: rtl/load_pipe_slice.sv
// One valid/ready register stage. Accepts when empty or when its contents
// leave downstream in the same cycle, so a chain of slices streams one item
// per cycle.
module load_pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data
);

  assign src_ready = !dst_valid || dst_ready;

  // Stage register: valid follows the upstream handshake, payload loads only
  // on an accepted transfer so it holds steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset too because it drives visible outputs
      // that must read 0 after reset, not just the valid flag.
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, which is what makes the slices chain correctly.
      if (src_ready) dst_valid <= src_valid;
      if (src_valid && src_ready) dst_data <= src_data;
    end
  end

endmodule

// File: rtl/load_extend_unit.sv
// Load extend unit for the MEM/WB path: picks the addressed byte/half/word/
// dword out of a raw memory word and zero- or sign-extends it to DATA_W.
// Stage 1 holds the selected field and its attributes, stage 2 the final
// extended result. A saturating counter tracks delivered misaligned loads.
module load_extend_unit
  import load_extend_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int TAG_W    = 5,
  parameter  int CNT_W    = 8,
  localparam int OFFSET_W = $clog2(DATA_W / 8)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [DATA_W-1:0]   InWord,
  input  logic [OFFSET_W-1:0] InOffset,
  input  logic [1:0]          InSize,
  input  logic                InSigned,
  input  logic [TAG_W-1:0]    InTag,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [DATA_W-1:0]   OutData,
  output logic [TAG_W-1:0]    OutTag,
  output logic                OutMisalign,
  input  logic                CountClear,
  output logic [CNT_W-1:0]    MisalignCount
);

  typedef struct packed {
    logic [DATA_W-1:0] field;
    logic              msb;
    logic [1:0]        size;
    logic              sign;
    logic [TAG_W-1:0]  tag;
    logic              misalign;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              misalign;
  } s2_t;

  // Bits belonging to the field for a given size; full width for the
  // widest legal access so that it passes through unextended.
  function automatic logic [DATA_W-1:0] size_mask(logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = '1;
    case (size)
      SIZE_BYTE: m = DATA_W'(8'hFF);
      SIZE_HALF: m = DATA_W'(16'hFFFF);
      SIZE_WORD: m = DATA_W'(32'hFFFF_FFFF);
      default:   m = '1;
    endcase
    return m;
  endfunction

  logic [DATA_W-1:0] shifted;
  s1_t               s1_in, s1_out;
  s2_t               s2_in, s2_out;
  logic              v1, ready1, ready2;
  logic [CNT_W-1:0]  count;

  // Stage 1 input: move the addressed field down to bit 0 and decide alignment.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    s1_in   = '0;
    shifted = InWord >> {InOffset, 3'b000};
    s1_in.field = shifted & size_mask(InSize);
    case (InSize)
      SIZE_BYTE: s1_in.msb = shifted[7];
      SIZE_HALF: s1_in.msb = shifted[15];
      SIZE_WORD: s1_in.msb = shifted[31];
      default:   s1_in.msb = shifted[DATA_W-1];
    endcase
    s1_in.size     = InSize;
    s1_in.sign     = InSigned;
    s1_in.tag      = InTag;
    s1_in.misalign = !is_aligned(size_e'(InSize), 3'(InOffset), DATA_W);
  end

  load_pipe_slice #(.WIDTH($bits(s1_t))) u_stage1 (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .src_valid (InValid),
    .src_ready (ready1),
    .src_data  (s1_in),
    .dst_valid (v1),
    .dst_ready (ready2),
    .dst_data  (s1_out)
  );

  // Stage 2 input: fill the upper bits with the field MSB or zeros; a
  // misaligned or illegal request yields zero data.
  always_comb begin
    s2_in          = '0;
    s2_in.tag      = s1_out.tag;
    s2_in.misalign = s1_out.misalign;
    if (!s1_out.misalign) begin
      s2_in.data = s1_out.field;
      if (s1_out.sign && s1_out.msb) s2_in.data = s1_out.field | ~size_mask(s1_out.size);
    end
  end

  load_pipe_slice #(.WIDTH($bits(s2_t))) u_stage2 (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .src_valid (v1),
    .src_ready (ready2),
    .src_data  (s2_in),
    .dst_valid (OutValid),
    .dst_ready (OutReady),
    .dst_data  (s2_out)
  );

  assign InReady     = ready1;
  assign OutData     = s2_out.data;
  assign OutTag      = s2_out.tag;
  assign OutMisalign = s2_out.misalign;

  // Misalignment counter: clear wins over a same-cycle increment, and it
  // holds at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (CountClear) begin
      count <= '0;
    end else if (OutValid && OutReady && OutMisalign && count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign MisalignCount = count;

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: a 32-bit instance driven through a scoreboard
// (expected results queued at acceptance, compared at each output handshake)
// and a 64-bit instance exercised with directed single requests.
module tb_load_extend_unit;

  localparam logic [31:0] W32 = 32'h80FF7F01;
  localparam logic [63:0] W64 = 64'h0123456780000000;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        mis;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_valid, a_ready, a_sgn, a_ovalid, a_oready, a_omis, a_clr;
  logic [31:0] a_word, a_odata;
  logic [1:0]  a_off, a_size;
  logic [4:0]  a_tag, a_otag;
  logic [7:0]  a_cnt;

  logic        b_valid, b_ready, b_sgn, b_ovalid, b_oready, b_omis, b_clr;
  logic [63:0] b_word, b_odata;
  logic [2:0]  b_off;
  logic [1:0]  b_size;
  logic [4:0]  b_tag, b_otag;
  logic [7:0]  b_cnt;

  int  tests = 0;
  int  fails = 0;
  sb_t sb[$];
  sb_t got;

  always #5 clk = ~clk;

  load_extend_unit #(.DATA_W(32), .TAG_W(5), .CNT_W(8)) d32 (
    .Clk(clk), .Reset_n(rst_n), .InValid(a_valid), .InReady(a_ready),
    .InWord(a_word), .InOffset(a_off), .InSize(a_size), .InSigned(a_sgn),
    .InTag(a_tag), .OutValid(a_ovalid), .OutReady(a_oready), .OutData(a_odata),
    .OutTag(a_otag), .OutMisalign(a_omis), .CountClear(a_clr), .MisalignCount(a_cnt)
  );

  load_extend_unit #(.DATA_W(64), .TAG_W(5), .CNT_W(8)) d64 (
    .Clk(clk), .Reset_n(rst_n), .InValid(b_valid), .InReady(b_ready),
    .InWord(b_word), .InOffset(b_off), .InSize(b_size), .InSigned(b_sgn),
    .InTag(b_tag), .OutValid(b_ovalid), .OutReady(b_oready), .OutData(b_odata),
    .OutTag(b_otag), .OutMisalign(b_omis), .CountClear(b_clr), .MisalignCount(b_cnt)
  );

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Scoreboard side: every output handshake of the 32-bit unit must match
  // the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && a_ovalid && a_oready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check("sb_data", 64'(a_odata), got.data);
        check("sb_tag",  64'(a_otag),  64'(got.tag));
        check("sb_mis",  64'(a_omis),  64'(got.mis));
      end
    end
  end

  // Present a request, wait (bounded) until accepted, queue its expectation.
  // Returns just after the accepting edge with the request still driven.
  task automatic drive32(logic [1:0] off, logic [1:0] sz, logic sg, logic [4:0] tg,
                         logic [31:0] exp_d, logic exp_m);
    int n;
    a_valid = 1'b1; a_word = W32; a_off = off; a_size = sz; a_sgn = sg; a_tag = tg;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept32", 64'(n < 50), 64'd1);
    sb.push_back('{data: 64'(exp_d), tag: tg, mis: exp_m});
    @(posedge clk); #1;
  endtask

  // Count edges from acceptance until OutValid; expects to be called just
  // after the accepting edge. Returns at the negedge where OutValid is seen.
  task automatic wait_out32();
    int lat;
    lat = 1;
    @(negedge clk);
    while (!a_ovalid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency32", 64'(lat), 64'd2);
  endtask

  task automatic one32(logic [1:0] off, logic [1:0] sz, logic sg, logic [4:0] tg,
                       logic [31:0] exp_d, logic exp_m);
    drive32(off, sz, sg, tg, exp_d, exp_m);
    a_valid = 1'b0;
    wait_out32();
    @(posedge clk); #1;
  endtask

  task automatic req64(string name, logic [2:0] off, logic [1:0] sz, logic sg,
                       logic [63:0] exp_d, logic exp_m);
    int n;
    b_valid = 1'b1; b_word = W64; b_off = off; b_size = sz; b_sgn = sg; b_tag = 5'd1;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_ovalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 64'(b_ovalid), 64'd1);
    check({name, "_data"},  b_odata,       exp_d);
    check({name, "_mis"},   64'(b_omis),   64'(exp_m));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_word = '0; a_off = '0; a_size = '0; a_sgn = 0; a_tag = '0;
    a_oready = 1'b1; a_clr = 1'b0;
    b_valid = 0; b_word = '0; b_off = '0; b_size = '0; b_sgn = 0; b_tag = '0;
    b_oready = 1'b1; b_clr = 1'b0;
    #1;
    check("rst_ovalid",  64'(a_ovalid), 64'd0);
    check("rst_odata",   64'(a_odata),  64'd0);
    check("rst_otag",    64'(a_otag),   64'd0);
    check("rst_cnt",     64'(a_cnt),    64'd0);
    check("rst_inready", 64'(a_ready),  64'd1);
    check("rst_ovalid64", 64'(b_ovalid), 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte and half reads, 32-bit
    one32(2'd1, 2'b00, 1'b1, 5'd1, 32'h0000007F, 1'b0);
    one32(2'd3, 2'b00, 1'b1, 5'd2, 32'hFFFFFF80, 1'b0);
    one32(2'd3, 2'b00, 1'b0, 5'd3, 32'h00000080, 1'b0);
    one32(2'd2, 2'b01, 1'b1, 5'd4, 32'hFFFF80FF, 1'b0);
    one32(2'd2, 2'b01, 1'b0, 5'd5, 32'h000080FF, 1'b0);
    one32(2'd0, 2'b10, 1'b1, 5'd6, 32'h80FF7F01, 1'b0);
    check("cnt_before_mis", 64'(a_cnt), 64'd0);
    one32(2'd1, 2'b01, 1'b1, 5'd7, 32'h00000000, 1'b1);
    check("cnt_after_half_mis", 64'(a_cnt), 64'd1);
    one32(2'd0, 2'b11, 1'b0, 5'd8, 32'h00000000, 1'b1);
    check("cnt_after_illegal", 64'(a_cnt), 64'd2);

    // Backpressure: three back-to-back requests while the consumer stalls
    a_oready = 1'b0;
    drive32(2'd1, 2'b00, 1'b0, 5'd3, 32'h0000007F, 1'b0);
    drive32(2'd2, 2'b00, 1'b0, 5'd4, 32'h000000FF, 1'b0);
    a_off = 2'd3; a_tag = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_inready", 64'(a_ready),  64'd0);
      check("bp_ovalid",  64'(a_ovalid), 64'd1);
      check("bp_otag",    64'(a_otag),   64'd3);
      check("bp_odata",   64'(a_odata),  64'h7F);
    end
    @(posedge clk); #1;
    a_oready = 1'b1;
    sb.push_back('{data: 64'h80, tag: 5'd5, mis: 1'b0});
    @(negedge clk);
    check("bp_order0_valid", 64'(a_ovalid), 64'd1);
    check("bp_order0_tag",   64'(a_otag),   64'd3);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("bp_order1_valid", 64'(a_ovalid), 64'd1);
    check("bp_order1_tag",   64'(a_otag),   64'd4);
    @(negedge clk);
    check("bp_order2_valid", 64'(a_ovalid), 64'd1);
    check("bp_order2_tag",   64'(a_otag),   64'd5);
    @(posedge clk); #1;

    // Asynchronous reset with both stages full
    a_oready = 1'b0;
    drive32(2'd0, 2'b00, 1'b0, 5'd10, 32'h01, 1'b0);
    drive32(2'd1, 2'b00, 1'b0, 5'd11, 32'h7F, 1'b0);
    a_valid = 1'b0;
    @(negedge clk);
    check("full_inready", 64'(a_ready),  64'd0);
    check("full_ovalid",  64'(a_ovalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ovalid", 64'(a_ovalid), 64'd0);
    check("async_cnt",    64'(a_cnt),    64'd0);
    check("async_odata",  64'(a_odata),  64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(a_ovalid), 64'd0);
    end
    @(posedge clk); #1;
    one32(2'd3, 2'b00, 1'b1, 5'd12, 32'hFFFFFF80, 1'b0);

    // 300 misaligned results saturate the counter
    for (int i = 0; i < 300; i++) drive32(2'd1, 2'b01, 1'b0, 5'(i), 32'h0, 1'b1);
    a_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cnt_saturated", 64'(a_cnt), 64'd255);
    check("sb_drained",    64'(sb.size()), 64'd0);

    // Clear in the same cycle as a misaligned output handshake
    drive32(2'd3, 2'b10, 1'b0, 5'd13, 32'h0, 1'b1);
    a_valid = 1'b0;
    wait_out32();
    check("cnt_held_255", 64'(a_cnt), 64'd255);
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    check("cnt_clear_priority", 64'(a_cnt), 64'd0);

    // 64-bit datapath
    req64("w64_off0_s",   3'd0, 2'b10, 1'b1, 64'hFFFFFFFF80000000, 1'b0);
    req64("w64_off4_u",   3'd4, 2'b10, 1'b0, 64'h0000000001234567, 1'b0);
    req64("dw64_off0",    3'd0, 2'b11, 1'b1, 64'h0123456780000000, 1'b0);
    req64("dw64_off4",    3'd4, 2'b11, 1'b0, 64'h0, 1'b1);
    req64("b64_off7_s",   3'd7, 2'b00, 1'b1, 64'h0000000000000001, 1'b0);
    req64("h64_off6_u",   3'd6, 2'b01, 1'b0, 64'h0000000000000123, 1'b0);
    check("cnt64", 64'(b_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Parametrised, pipelined successor to the 8-to-32 sign-extend block. Sits in the MEM/WB path of the datapath.
- Takes the raw memory word, the byte offset, the access size and a signed flag. Extracts the addressed byte, half, word or dword and zero- or sign-extends it to DATA_W.
- Uses a valid/ready handshake, a two-stage pipeline and a saturating misalignment counter.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the destination-register tag carried alongside the data.
- CNT_W, 8, width of the misalignment counter.
- OFFSET_W, derived as log2(DATA_W/8); localparam, not overridable.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  unit can accept a request this cycle.
- InWord  in  DATA_W  raw aligned memory word.
- InOffset  in  OFFSET_W  byte address low bits.
- InSize  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- InSigned  in  1  1 = sign-extend, 0 = zero-extend.
- InTag  in  TAG_W  destination tag.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- OutData  out  DATA_W  extended result.
- OutTag  out  TAG_W  tag paired with OutData.
- OutMisalign  out  1  request was misaligned or used an illegal size.
- CountClear  in  1  synchronous clear of MisalignCount.
- MisalignCount  out  CNT_W  saturating count of misaligned results delivered.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - OutValid, OutData, OutTag, OutMisalign, MisalignCount and both stage-valid flags go to 0 immediately.
  - In-flight requests are discarded. No output appears after release until a new request is accepted.
- Handshakes: a transfer occurs when Valid and Ready are both 1 at a rising edge.
  - Stage 2 ready = !v2 | OutReady.
  - Stage 1 ready = !v1 | stage-2 ready.
  - InReady = stage-1 ready; a combinational chain is permitted.
- Latency and throughput: 2 cycles from the accepting edge to OutValid when OutReady is held at 1. Throughput is 1 request per cycle.
- Stage 1 registers:
  - the selected field, shifted to bit 0;
  - the field MSB;
  - size, signed flag, tag, and the misalign decision.
- Stage 2 registers the extended result.
- Field selection: field = InWord[8*InOffset +: 8*bytes(InSize)].
- Alignment rules:
  - half requires InOffset[0]=0;
  - word requires InOffset[1:0]=0;
  - dword requires InOffset=0.
  - Size 11 with DATA_W=32 is illegal.
  - A misaligned or illegal request still flows through as a transaction, with OutMisalign=1 and OutData=0.
- Extension:
  - InSigned=1: upper bits are copies of the field MSB.
  - InSigned=0: upper bits are 0.
  - A full-width access (word at 32, dword at 64) passes through unchanged regardless of InSigned.
- Output stability: OutData, OutTag and OutMisalign hold stable while OutValid=1 and OutReady=0. Stage registers load only on a handshake into that stage.
- Ordering: strictly in order; no reordering or dropping under backpressure.
- MisalignCount:
  - increments on an output handshake with OutMisalign=1;
  - saturates at 2^CNT_W-1 (no wrap);
  - CountClear has priority over a same-cycle increment, giving 0.
- Only the CountClear input is synchronous; reset is asynchronous only.

Decomposition:
- Package load_extend_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD;
  - a function size_bytes(size) returning 1/2/4/8;
  - a function is_aligned(size, offset, data_w).
- One natural sub-module, load_pipe_slice: a single valid/ready register stage with a parametrised payload width. It is instantiated twice; select/extend logic stays in the top module.

Test Plan:
- DATA_W=32, InWord=32'h80FF7F01, byte reads with OutReady=1:
  - off=1, signed -> OutData 32'h0000007F, 2 cycles after accept.
  - off=3, signed -> 32'hFFFFFF80.
  - off=3, unsigned -> 32'h00000080.
- Same word, half reads:
  - off=2, signed -> 32'hFFFF80FF.
  - off=2, unsigned -> 32'h000080FF.
  - off=1 -> OutMisalign=1, OutData=0, MisalignCount 0->1.
  - size=11 -> misaligned; count increments.
- Backpressure: OutReady=0 for 5 cycles while 3 back-to-back requests (tags 3,4,5) are offered:
  - tags 3 and 4 are accepted, then InReady=0;
  - OutData/OutTag stay stable;
  - on release, outputs appear in order 3,4,5 on consecutive cycles.
- Reset_n pulsed low for 1 cycle with both stages full:
  - OutValid=0 asynchronously and MisalignCount=0;
  - no output until the next accepted request, which emerges after 2 cycles.
- DATA_W=64, InWord=64'h0123456780000000:
  - word off=0, signed -> 64'hFFFFFFFF80000000;
  - word off=4, unsigned -> 64'h0000000001234567;
  - dword off=0 -> word passes unchanged;
  - dword off=4 -> misaligned.
- Counter: 300 consecutive misaligned results -> MisalignCount=255 (CNT_W=8). CountClear in the same cycle as a misaligned handshake -> 0.
